// File: rtl/ace_snoop_pkg.sv
// ace_snoop_pkg
// Shared definitions for the ACE snoop responder: snoop opcodes, CR response
// bit positions, the responder FSM encoding and the snoop decode function
// that maps (opcode, lookup result) to the response, data and update actions.
package ace_snoop_pkg;

    localparam logic [3:0] SNP_READ_ONCE     = 4'b0000;
    localparam logic [3:0] SNP_READ_SHARED   = 4'b0001;
    localparam logic [3:0] SNP_READ_CLEAN    = 4'b0010;
    localparam logic [3:0] SNP_READ_NSD      = 4'b0011;
    localparam logic [3:0] SNP_READ_UNIQUE   = 4'b0111;
    localparam logic [3:0] SNP_CLEAN_SHARED  = 4'b1000;
    localparam logic [3:0] SNP_CLEAN_INVALID = 4'b1001;
    localparam logic [3:0] SNP_MAKE_INVALID  = 4'b1101;

    // crresp = {WasUnique, IsShared, PassDirty, Error, DataTransfer}
    localparam int CR_DT  = 0;
    localparam int CR_ERR = 1;
    localparam int CR_PD  = 2;
    localparam int CR_IS  = 3;
    localparam int CR_WU  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_RESP   = 2'd2,
        ST_DATA   = 2'd3
    } snoop_state_e;

    typedef struct packed {
        logic [4:0] crresp;
        logic       need_data;
        logic       upd_inval;
        logic       upd_clr_dirty;
    } snoop_dec_t;

    function automatic logic snoop_known(input logic [3:0] snoop);
        case (snoop)
            SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD,
            SNP_READ_UNIQUE, SNP_CLEAN_SHARED, SNP_CLEAN_INVALID,
            SNP_MAKE_INVALID: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    // A miss on a known opcode yields an all-zero response with no side effects.
    function automatic snoop_dec_t snoop_decode(input logic [3:0] snoop,
                                                input logic hit,
                                                input logic is_unique,
                                                input logic is_dirty);
        snoop_dec_t d;
        d = '0;
        if (!snoop_known(snoop)) begin
            d.crresp[CR_ERR] = 1'b1;
        end else if (hit) begin
            d.crresp[CR_WU] = is_unique;
            case (snoop)
                SNP_READ_ONCE: begin
                    d.crresp[CR_DT] = 1'b1;
                    d.crresp[CR_IS] = 1'b1;
                    d.need_data     = 1'b1;
                end
                SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD: begin
                    d.crresp[CR_DT] = 1'b1;
                    d.crresp[CR_IS] = 1'b1;
                    d.crresp[CR_PD] = is_dirty;
                    d.need_data     = 1'b1;
                    d.upd_clr_dirty = is_dirty;
                end
                SNP_READ_UNIQUE: begin
                    d.crresp[CR_DT] = 1'b1;
                    d.crresp[CR_PD] = is_dirty;
                    d.need_data     = 1'b1;
                    d.upd_inval     = 1'b1;
                end
                SNP_CLEAN_SHARED: begin
                    d.crresp[CR_DT] = is_dirty;
                    d.crresp[CR_PD] = is_dirty;
                    d.crresp[CR_IS] = 1'b1;
                    d.need_data     = is_dirty;
                    d.upd_clr_dirty = is_dirty;
                end
                SNP_CLEAN_INVALID: begin
                    d.crresp[CR_DT] = is_dirty;
                    d.crresp[CR_PD] = is_dirty;
                    d.need_data     = is_dirty;
                    d.upd_inval     = 1'b1;
                end
                default: begin
                    d.upd_inval = 1'b1;
                end
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/ace_snoop_cd_pipe.sv
// ace_snoop_cd_pipe
// CD channel datapath: issues wrap-ordered beat reads starting at the critical
// beat and presents the returned data through a two-entry skid register so
// cddata/cdvalid stay stable under backpressure at full throughput.
// Ports:
//   ACLK, ARESETn        clock, async active-low reset
//   clr                  return counters/buffer to empty (responder idle)
//   issue_ok             reads may be issued this cycle
//   out_en               beats may be presented on CD
//   line_base, crit_beat line address and first beat index
//   rd_en/rd_addr/rd_data  data-array read port (data one cycle after rd_en)
//   cdvalid/cdready/cddata/cdlast  CD channel
//   done                 handshake of the final beat
module ace_snoop_cd_pipe
    import ace_snoop_pkg::*;
#(
    parameter int ADDR_WIDTH    = 64,
    parameter int CD_DATA_WIDTH = 128,
    parameter int BYTE_LOG2     = 4,
    parameter int BEAT_LOG2     = 2
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     clr,
    input  logic                     issue_ok,
    input  logic                     out_en,
    input  logic [ADDR_WIDTH-1:0]    line_base,
    input  logic [BEAT_LOG2:0]       crit_beat,
    output logic                     rd_en,
    output logic [ADDR_WIDTH-1:0]    rd_addr,
    input  logic [CD_DATA_WIDTH-1:0] rd_data,
    output logic                     cdvalid,
    input  logic                     cdready,
    output logic [CD_DATA_WIDTH-1:0] cddata,
    output logic                     cdlast,
    output logic                     done
);
    localparam int CNT_W = BEAT_LOG2 + 1;
    localparam logic [CNT_W-1:0] BEATS_C  = CNT_W'(1 << BEAT_LOG2);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << BEAT_LOG2) - 1);

    logic [CNT_W-1:0]         issued, popped, beat_idx;
    logic [1:0]               cnt;
    logic                     pend, pop;
    logic [2:0]               occ;
    logic [CD_DATA_WIDTH-1:0] buf0, buf1;

    assign cdvalid = out_en && (cnt != 2'd0);
    assign pop     = cdvalid && cdready;
    assign cddata  = buf0;
    assign cdlast  = cdvalid && (popped == LAST_IDX);
    assign done    = pop && cdlast;

    // Occupancy after this edge, assuming no drain next cycle; a new read is
    // only issued if its data is guaranteed a slot when it returns.
    assign occ      = {1'b0, cnt} + {2'b0, pend} - {2'b0, pop};
    assign rd_en    = issue_ok && (issued != BEATS_C) && (occ <= 3'd1);
    assign beat_idx = (crit_beat + issued) & LAST_IDX;
    assign rd_addr  = line_base | (ADDR_WIDTH'(beat_idx) << BYTE_LOG2);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            issued <= '0;
            popped <= '0;
            cnt    <= 2'd0;
            pend   <= 1'b0;
            buf0   <= '0;
            buf1   <= '0;
        end else if (clr) begin
            issued <= '0;
            popped <= '0;
            cnt    <= 2'd0;
            pend   <= 1'b0;
        end else begin
            pend <= rd_en;
            if (rd_en) issued <= issued + CNT_W'(1);
            if (pop)   popped <= popped + CNT_W'(1);
            case ({pend, pop})
                2'b10: begin
                    if (cnt == 2'd0) buf0 <= rd_data;
                    else             buf1 <= rd_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd2) begin
                        buf0 <= buf1;
                        buf1 <= rd_data;
                    end else begin
                        buf0 <= rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder
// ACE master snoop agent: accepts one AC snoop at a time, looks the line up in
// an external single-cycle cache-state model, answers on CR, returns the full
// line on CD in wrap order when data is owed, and pulses one state update.
// Ports:
//   ACLK, ARESETn                       clock, async active-low reset
//   acvalid/acready/acaddr/acsnoop      AC snoop request channel
//   crvalid/crready/crresp              CR snoop response channel
//   cdvalid/cdready/cddata/cdlast       CD snoop data channel
//   lk_req/lk_addr/lk_hit/lk_unique/lk_dirty  cache-state lookup
//   rd_en/rd_addr/rd_data               line data read port
//   upd_valid/upd_addr/upd_inval/upd_clr_dirty  cache-state update
//
// state  | meaning
// IDLE   | acready=1, waiting for a snoop
// LOOKUP | lookup strobe; response latched; critical beat prefetched on hit
// RESP   | crvalid held until crready; update pulses on the handshake
// DATA   | remaining beats streamed on CD until the cdlast handshake
module ace_snoop_responder
    import ace_snoop_pkg::*;
#(
    parameter int ADDR_WIDTH      = 64,
    parameter int CD_DATA_WIDTH   = 128,
    parameter int CACHE_LINE_LOG2 = 6
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     acvalid,
    output logic                     acready,
    input  logic [ADDR_WIDTH-1:0]    acaddr,
    input  logic [3:0]               acsnoop,
    output logic                     crvalid,
    input  logic                     crready,
    output logic [4:0]               crresp,
    output logic                     cdvalid,
    input  logic                     cdready,
    output logic [CD_DATA_WIDTH-1:0] cddata,
    output logic                     cdlast,
    output logic                     lk_req,
    output logic [ADDR_WIDTH-1:0]    lk_addr,
    input  logic                     lk_hit,
    input  logic                     lk_unique,
    input  logic                     lk_dirty,
    output logic                     rd_en,
    output logic [ADDR_WIDTH-1:0]    rd_addr,
    input  logic [CD_DATA_WIDTH-1:0] rd_data,
    output logic                     upd_valid,
    output logic [ADDR_WIDTH-1:0]    upd_addr,
    output logic                     upd_inval,
    output logic                     upd_clr_dirty
);
    localparam int BYTE_LOG2 = $clog2(CD_DATA_WIDTH / 8);
    localparam int BEAT_LOG2 = CACHE_LINE_LOG2 - BYTE_LOG2;
    localparam int CNT_W     = BEAT_LOG2 + 1;
    localparam logic [ADDR_WIDTH-1:0] OFS_MASK =
        ADDR_WIDTH'((64'd1 << CACHE_LINE_LOG2) - 64'd1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_MASK =
        ADDR_WIDTH'((64'd1 << BEAT_LOG2) - 64'd1);

    snoop_state_e          state;
    logic [ADDR_WIDTH-1:0] ac_addr_q, line_base;
    logic [3:0]            snoop_q;
    logic [4:0]            crresp_q;
    logic                  need_data_q, upd_inval_q, upd_clr_q;
    logic [CNT_W-1:0]      crit_beat;
    logic                  cd_done;
    snoop_dec_t            dec;

    assign dec       = snoop_decode(snoop_q, lk_hit, lk_unique, lk_dirty);
    assign line_base = ac_addr_q & ~OFS_MASK;
    assign crit_beat = CNT_W'((ac_addr_q >> BYTE_LOG2) & BEAT_MASK);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state       <= ST_IDLE;
            ac_addr_q   <= '0;
            snoop_q     <= 4'd0;
            crresp_q    <= 5'd0;
            need_data_q <= 1'b0;
            upd_inval_q <= 1'b0;
            upd_clr_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (acvalid) begin
                        ac_addr_q <= acaddr;
                        snoop_q   <= acsnoop;
                        state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    crresp_q    <= dec.crresp;
                    need_data_q <= dec.need_data;
                    upd_inval_q <= dec.upd_inval;
                    upd_clr_q   <= dec.upd_clr_dirty;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (crready) state <= need_data_q ? ST_DATA : ST_IDLE;
                end
                ST_DATA: begin
                    if (cd_done) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign acready = (state == ST_IDLE);
    // Unknown opcodes must not touch the cache model.
    assign lk_req  = (state == ST_LOOKUP) && snoop_known(snoop_q);
    assign lk_addr = line_base;
    assign crvalid = (state == ST_RESP);
    assign crresp  = crvalid ? crresp_q : 5'd0;

    assign upd_valid     = crvalid && crready && (upd_inval_q || upd_clr_q);
    assign upd_addr      = line_base;
    assign upd_inval     = upd_valid && upd_inval_q;
    assign upd_clr_dirty = upd_valid && upd_clr_q;

    // The critical beat is read during LOOKUP so it is already buffered when
    // the CR handshake completes.
    ace_snoop_cd_pipe #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .CD_DATA_WIDTH (CD_DATA_WIDTH),
        .BYTE_LOG2     (BYTE_LOG2),
        .BEAT_LOG2     (BEAT_LOG2)
    ) u_cd_pipe (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .clr       (state == ST_IDLE),
        .issue_ok  (((state == ST_LOOKUP) && dec.need_data) || (state == ST_DATA)),
        .out_en    (state == ST_DATA),
        .line_base (line_base),
        .crit_beat (crit_beat),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .cdvalid   (cdvalid),
        .cdready   (cdready),
        .cddata    (cddata),
        .cdlast    (cdlast),
        .done      (cd_done)
    );

endmodule

// File: tb/tb_ace_snoop_responder.sv
module tb_ace_snoop_responder;
    import ace_snoop_pkg::*;

    localparam int AW = 64;
    localparam int DW = 128;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic          acvalid = 1'b0, acready;
    logic [AW-1:0] acaddr = '0;
    logic [3:0]    acsnoop = 4'd0;
    logic          crvalid, crready = 1'b0;
    logic [4:0]    crresp;
    logic          cdvalid, cdready = 1'b1, cdlast;
    logic [DW-1:0] cddata;
    logic          lk_req;
    logic [AW-1:0] lk_addr;
    logic          lk_hit = 1'b0, lk_unique = 1'b0, lk_dirty = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          upd_valid, upd_inval, upd_clr_dirty;
    logic [AW-1:0] upd_addr;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [AW-1:0] rd_q[$];
    logic [DW-1:0] cd_q[$];
    logic          cdlast_q[$];
    int            upd_cnt = 0;
    logic [AW-1:0] upd_addr_seen = '0;
    logic          upd_clr_seen = 1'b0;

    always #5 ACLK = ~ACLK;

    ace_snoop_responder #(
        .ADDR_WIDTH(AW), .CD_DATA_WIDTH(DW), .CACHE_LINE_LOG2(6)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .acvalid(acvalid), .acready(acready), .acaddr(acaddr), .acsnoop(acsnoop),
        .crvalid(crvalid), .crready(crready), .crresp(crresp),
        .cdvalid(cdvalid), .cdready(cdready), .cddata(cddata), .cdlast(cdlast),
        .lk_req(lk_req), .lk_addr(lk_addr),
        .lk_hit(lk_hit), .lk_unique(lk_unique), .lk_dirty(lk_dirty),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .upd_valid(upd_valid), .upd_addr(upd_addr),
        .upd_inval(upd_inval), .upd_clr_dirty(upd_clr_dirty)
    );

    function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a);
        return {a[31:0], ~a[31:0], a[31:0] + 32'h1111, 32'hDEAD0000 | {16'h0, a[15:0]}};
    endfunction

    // Data-array model: registered read, data valid the cycle after rd_en.
    always @(posedge ACLK) if (rd_en) rd_data <= beat_data(rd_addr);

    always @(posedge ACLK) begin
        if (rd_en) rd_q.push_back(rd_addr);
        if (cdvalid && cdready) begin
            cd_q.push_back(cddata);
            cdlast_q.push_back(cdlast);
        end
        if (upd_valid) begin
            upd_cnt++;
            upd_addr_seen = upd_addr;
            upd_clr_seen  = upd_clr_dirty;
        end
    end

    task automatic clear_log();
        rd_q.delete();
        cd_q.delete();
        cdlast_q.delete();
        upd_cnt = 0;
    endtask

    // Presents a snoop for one cycle; returns at the negedge of the LOOKUP cycle.
    task automatic send_ac(input logic [AW-1:0] a, input logic [3:0] s);
        @(negedge ACLK);
        acaddr  = a;
        acsnoop = s;
        acvalid = 1'b1;
        @(negedge ACLK);
        acvalid = 1'b0;
    endtask

    task automatic wait_crvalid(output bit to);
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (crvalid) begin
                to = 1'b0;
                break;
            end
            @(negedge ACLK);
        end
    endtask

    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (acready) begin
                to = 1'b0;
                break;
            end
            @(negedge ACLK);
        end
    endtask

    task automatic test_reset();
        @(negedge ACLK);
        vec_cnt++;
        if ({acready, crvalid, cdvalid, upd_valid, rd_en, lk_req, cdlast, crresp} !== {7'b1000000, 5'd0}) begin
            err_cnt++;
            $display("FAIL reset_in: got %b expected %b",
                     {acready, crvalid, cdvalid, upd_valid, rd_en, lk_req, cdlast, crresp}, {7'b1000000, 5'd0});
        end
        ARESETn = 1'b1;
        @(negedge ACLK);
        vec_cnt++;
        if ({acready, crvalid, cdvalid, upd_valid} !== 4'b1000) begin
            err_cnt++;
            $display("FAIL reset_out: got %b expected 1000", {acready, crvalid, cdvalid, upd_valid});
        end
    endtask

    task automatic test_read_shared();
        logic [AW-1:0] exp_a [4];
        bit to;
        exp_a = '{64'h1030, 64'h1000, 64'h1010, 64'h1020};
        clear_log();
        lk_hit = 1'b1; lk_unique = 1'b1; lk_dirty = 1'b1;
        crready = 1'b0; cdready = 1'b1;
        send_ac(64'h1030, SNP_READ_SHARED);
        vec_cnt++;
        if ({lk_req, lk_addr, crvalid} !== {1'b1, 64'h1000, 1'b0}) begin
            err_cnt++;
            $display("FAIL rs_lookup: got req=%b addr=%h crvalid=%b expected 1 1000 0", lk_req, lk_addr, crvalid);
        end
        vec_cnt++;
        if ({rd_en, rd_addr} !== {1'b1, 64'h1030}) begin
            err_cnt++;
            $display("FAIL rs_prefetch: got rd_en=%b rd_addr=%h expected 1 1030", rd_en, rd_addr);
        end
        @(negedge ACLK);
        vec_cnt++;
        if ({crvalid, crresp, acready} !== {1'b1, 5'b11101, 1'b0}) begin
            err_cnt++;
            $display("FAIL rs_crresp: got v=%b resp=%b acready=%b expected 1 11101 0", crvalid, crresp, acready);
        end
        @(negedge ACLK);
        vec_cnt++;
        if ({crvalid, crresp, cdvalid, upd_valid} !== {1'b1, 5'b11101, 1'b0, 1'b0}) begin
            err_cnt++;
            $display("FAIL rs_cr_stall: got v=%b resp=%b cdv=%b upd=%b expected 1 11101 0 0",
                     crvalid, crresp, cdvalid, upd_valid);
        end
        crready = 1'b1;
        #1;
        vec_cnt++;
        if ({upd_valid, upd_addr, upd_inval, upd_clr_dirty} !== {1'b1, 64'h1000, 1'b0, 1'b1}) begin
            err_cnt++;
            $display("FAIL rs_update: got v=%b addr=%h inval=%b clr=%b expected 1 1000 0 1",
                     upd_valid, upd_addr, upd_inval, upd_clr_dirty);
        end
        @(negedge ACLK);
        crready = 1'b0;
        vec_cnt++;
        if ({cdvalid, cddata, cdlast, crvalid} !== {1'b1, beat_data(64'h1030), 1'b0, 1'b0}) begin
            err_cnt++;
            $display("FAIL rs_first_cd: got v=%b data=%h last=%b expected 1 %h 0",
                     cdvalid, cddata, cdlast, beat_data(64'h1030));
        end
        wait_idle(to);
        vec_cnt++;
        if (to) begin
            err_cnt++;
            $display("FAIL rs_timeout: got no return to idle, required idle within 60 cycles");
        end
        vec_cnt++;
        if (rd_q.size() != 4 || cd_q.size() != 4) begin
            err_cnt++;
            $display("FAIL rs_beat_count: got rd=%0d cd=%0d expected 4 4", rd_q.size(), cd_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vec_cnt++;
                if ({rd_q[i], cd_q[i], cdlast_q[i]} !== {exp_a[i], beat_data(exp_a[i]), (i == 3)}) begin
                    err_cnt++;
                    $display("FAIL rs_beat%0d: got addr=%h last=%b expected addr=%h last=%b",
                             i, rd_q[i], cdlast_q[i], exp_a[i], (i == 3));
                end
            end
        end
        vec_cnt++;
        if (upd_cnt != 1) begin
            err_cnt++;
            $display("FAIL rs_upd_count: got %0d expected 1", upd_cnt);
        end
    endtask

    task automatic test_clean_invalid();
        bit to;
        clear_log();
        lk_hit = 1'b1; lk_unique = 1'b1; lk_dirty = 1'b0;
        crready = 1'b1; cdready = 1'b1;
        send_ac(64'h2040, SNP_CLEAN_INVALID);
        wait_crvalid(to);
        vec_cnt++;
        if (to || crresp !== 5'b10000) begin
            err_cnt++;
            $display("FAIL ci_crresp: got to=%b resp=%b expected 0 10000", to, crresp);
        end
        vec_cnt++;
        if ({upd_valid, upd_addr, upd_inval, upd_clr_dirty} !== {1'b1, 64'h2040, 1'b1, 1'b0}) begin
            err_cnt++;
            $display("FAIL ci_update: got v=%b addr=%h inval=%b clr=%b expected 1 2040 1 0",
                     upd_valid, upd_addr, upd_inval, upd_clr_dirty);
        end
        @(negedge ACLK);
        vec_cnt++;
        if ({acready, cdvalid} !== 2'b10 || rd_q.size() != 0 || cd_q.size() != 0) begin
            err_cnt++;
            $display("FAIL ci_no_data: got acready=%b cdv=%b rd=%0d cd=%0d expected 1 0 0 0",
                     acready, cdvalid, rd_q.size(), cd_q.size());
        end
    endtask

    task automatic test_read_unique_miss();
        bit to;
        clear_log();
        lk_hit = 1'b0; lk_unique = 1'b1; lk_dirty = 1'b1;
        crready = 1'b1;
        send_ac(64'h3000, SNP_READ_UNIQUE);
        wait_crvalid(to);
        vec_cnt++;
        if (to || crresp !== 5'b00000 || upd_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL ru_miss: got to=%b resp=%b upd=%b expected 0 00000 0", to, crresp, upd_valid);
        end
        @(negedge ACLK);
        vec_cnt++;
        if (acready !== 1'b1) begin
            err_cnt++;
            $display("FAIL ru_acready: got %b expected 1", acready);
        end
        vec_cnt++;
        if (rd_q.size() + cd_q.size() + upd_cnt != 0) begin
            err_cnt++;
            $display("FAIL ru_side_effects: got rd=%0d cd=%0d upd=%0d expected 0 0 0",
                     rd_q.size(), cd_q.size(), upd_cnt);
        end
    endtask

    task automatic test_bad_opcode();
        bit to;
        clear_log();
        lk_hit = 1'b1; lk_unique = 1'b1; lk_dirty = 1'b1;
        crready = 1'b1;
        send_ac(64'h3440, 4'b0101);
        wait_crvalid(to);
        vec_cnt++;
        if (to || crresp !== 5'b00010 || upd_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL bad_op: got to=%b resp=%b upd=%b expected 0 00010 0", to, crresp, upd_valid);
        end
        @(negedge ACLK);
        vec_cnt++;
        if (acready !== 1'b1 || rd_q.size() + cd_q.size() + upd_cnt != 0) begin
            err_cnt++;
            $display("FAIL bad_op_side: got acready=%b rd=%0d cd=%0d upd=%0d expected 1 0 0 0",
                     acready, rd_q.size(), cd_q.size(), upd_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] exp_a [4];
        int            pat [4];
        logic [DW-1:0] held;
        bit            stalled, to;
        exp_a = '{64'h3010, 64'h3020, 64'h3030, 64'h3000};
        pat   = '{1, 0, 0, 1};
        clear_log();
        lk_hit = 1'b1; lk_unique = 1'b0; lk_dirty = 1'b0;
        crready = 1'b1; cdready = 1'b1;
        send_ac(64'h3010, SNP_READ_ONCE);
        wait_crvalid(to);
        vec_cnt++;
        if (to || crresp !== 5'b01001 || upd_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_crresp: got to=%b resp=%b upd=%b expected 0 01001 0", to, crresp, upd_valid);
        end
        @(negedge ACLK);
        stalled = 1'b0;
        held    = '0;
        to      = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (acready) begin
                to = 1'b0;
                break;
            end
            if (stalled) begin
                vec_cnt++;
                if ({cdvalid, cddata} !== {1'b1, held}) begin
                    err_cnt++;
                    $display("FAIL bp_stable: got v=%b data=%h expected 1 %h", cdvalid, cddata, held);
                end
            end
            cdready = (pat[i % 4] != 0);
            #1;
            stalled = cdvalid && !cdready;
            held    = cddata;
            @(negedge ACLK);
        end
        cdready = 1'b1;
        vec_cnt++;
        if (to || cd_q.size() != 4) begin
            err_cnt++;
            $display("FAIL bp_beats: got to=%b beats=%0d expected 0 4", to, cd_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vec_cnt++;
                if ({cd_q[i], cdlast_q[i]} !== {beat_data(exp_a[i]), (i == 3)}) begin
                    err_cnt++;
                    $display("FAIL bp_beat%0d: got data=%h last=%b expected %h %b",
                             i, cd_q[i], cdlast_q[i], beat_data(exp_a[i]), (i == 3));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] exp_a [4];
        bit to;
        exp_a = '{64'h5020, 64'h5030, 64'h5000, 64'h5010};
        clear_log();
        lk_hit = 1'b1; lk_unique = 1'b1; lk_dirty = 1'b0;
        crready = 1'b1; cdready = 1'b1;
        send_ac(64'h4000, SNP_READ_ONCE);
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cd_q.size() == 1 && cdvalid) begin
                to = 1'b0;
                break;
            end
            @(negedge ACLK);
        end
        vec_cnt++;
        if (to) begin
            err_cnt++;
            $display("FAIL rm_second_beat: got no second beat, required one within 20 cycles");
        end
        ARESETn = 1'b0;
        #1;
        vec_cnt++;
        if ({crvalid, cdvalid, upd_valid, rd_en, lk_req} !== 5'b00000) begin
            err_cnt++;
            $display("FAIL rm_abort: got %b expected 00000", {crvalid, cdvalid, upd_valid, rd_en, lk_req});
        end
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        vec_cnt++;
        if ({acready, cdvalid} !== 2'b10 || upd_cnt != 0) begin
            err_cnt++;
            $display("FAIL rm_release: got acready=%b cdv=%b upd=%0d expected 1 0 0", acready, cdvalid, upd_cnt);
        end
        clear_log();
        lk_dirty = 1'b1;
        send_ac(64'h5020, SNP_READ_SHARED);
        wait_crvalid(to);
        vec_cnt++;
        if (to || crresp !== 5'b11101) begin
            err_cnt++;
            $display("FAIL rm_next_crresp: got to=%b resp=%b expected 0 11101", to, crresp);
        end
        @(negedge ACLK);
        wait_idle(to);
        vec_cnt++;
        if (to || rd_q.size() != 4 || cd_q.size() != 4) begin
            err_cnt++;
            $display("FAIL rm_next_count: got to=%b rd=%0d cd=%0d expected 0 4 4", to, rd_q.size(), cd_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vec_cnt++;
                if ({rd_q[i], cd_q[i], cdlast_q[i]} !== {exp_a[i], beat_data(exp_a[i]), (i == 3)}) begin
                    err_cnt++;
                    $display("FAIL rm_next_beat%0d: got addr=%h last=%b expected %h %b",
                             i, rd_q[i], cdlast_q[i], exp_a[i], (i == 3));
                end
            end
        end
        vec_cnt++;
        if (upd_cnt != 1 || upd_addr_seen !== 64'h5000 || upd_clr_seen !== 1'b1) begin
            err_cnt++;
            $display("FAIL rm_next_update: got cnt=%0d addr=%h clr=%b expected 1 5000 1",
                     upd_cnt, upd_addr_seen, upd_clr_seen);
        end
    endtask

    initial begin
        repeat (2) @(negedge ACLK);
        test_reset();
        test_read_shared();
        test_clean_invalid();
        test_read_unique_miss();
        test_bad_opcode();
        test_backpressure();
        test_reset_mid();
        repeat (2) @(negedge ACLK);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ace_snoop_responder.md
Name: ace_snoop_responder

Overview:
- Synthesizable HDL-side ACE master snoop agent; consumes AC snoop requests from the interconnect and produces CR responses and CD data.
- Sits beside the ACE master BFM in the HDL top, driving the snoop channels of the same ACE port.
- Queries an external single-cycle cache-state model, returns full-line data in wrap order, and emits one state-update pulse per snoop.
- One snoop in flight at a time.

Parameters:
- ADDR_WIDTH, 64, AC/lookup address width
- CD_DATA_WIDTH, 128, CD beat width in bits (power of 2, >=32)
- CACHE_LINE_LOG2, 6, log2 of line size in bytes; beats = 2^CACHE_LINE_LOG2 / (CD_DATA_WIDTH/8), >=1

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- acvalid/acready  in/out  1/1  AC handshake
- acaddr  in  ADDR_WIDTH  snoop address
- acsnoop  in  4  snoop type
- crvalid/crready  out/in  1/1  CR handshake
- crresp  out  5  {WasUnique,IsShared,PassDirty,Error,DataTransfer}
- cdvalid/cdready  out/in  1/1  CD handshake
- cddata  out  CD_DATA_WIDTH  snoop data
- cdlast  out  1  final beat
- lk_req  out  1  lookup strobe
- lk_addr  out  ADDR_WIDTH  line-aligned lookup address
- lk_hit/lk_unique/lk_dirty  in  1 each  combinational same-cycle lookup result
- rd_en  out  1  data read strobe
- rd_addr  out  ADDR_WIDTH  beat address
- rd_data  in  CD_DATA_WIDTH  valid the cycle after rd_en
- upd_valid  out  1  one-cycle state-update pulse
- upd_addr  out  ADDR_WIDTH  line address
- upd_inval/upd_clr_dirty  out  1/1  invalidate / make clean

Behaviour:
- Reset values: all outputs 0 except acready=1; FSM=IDLE.
- IDLE: acready=1. On acvalid&acready, latch acaddr and acsnoop, then go to LOOKUP.
- LOOKUP (1 cycle): lk_req=1 and lk_addr=line base. Latch hit/unique/dirty, compute crresp/need_data/update, then go to RESP.
- RESP: crvalid=1 and crresp held stable until crready. On handshake, pulse upd_valid if an update is needed. Then go to DATA if need_data, else IDLE.
- DATA:
  - Beat order starts at the critical beat, acaddr[CACHE_LINE_LOG2-1:log2(CD_DATA_WIDTH/8)], and increments modulo the beat count.
  - rd_en is issued when the output register is empty or draining this cycle.
  - rd_data is loaded into cddata one cycle later with cdvalid=1; cddata/cdvalid are stable under backpressure.
  - cdlast is set on the final beat; go to IDLE after its handshake.
- Snoop encoding for a hit (miss gives crresp=0, no data, no update):
  - 0000 ReadOnce: DT=1, IsShared=1, WasUnique=unique, PassDirty=0; no update.
  - 0001/0010/0011 ReadShared/ReadClean/ReadNotSharedDirty: DT=1, IsShared=1, PassDirty=dirty, WasUnique=unique; update clr_dirty=dirty.
  - 0111 ReadUnique: DT=1, PassDirty=dirty, WasUnique=unique; update inval=1.
  - 1000 CleanShared: DT=dirty, PassDirty=dirty, IsShared=1, WasUnique=unique; update clr_dirty=dirty.
  - 1001 CleanInvalid: DT=dirty, PassDirty=dirty, WasUnique=unique; update inval=1.
  - 1101 MakeInvalid: all 0 except WasUnique=unique; update inval=1.
  - Any other code: Error=1, all others 0, no lookup side effects, no update, no data.
- Latency: the earliest crvalid is 2 cycles after the AC handshake. The first cdvalid comes 1 cycle after the CR handshake, provided no backpressure.
- Reset mid-operation: the FSM aborts to IDLE, all valids drop immediately, and no update is issued.
- crready held low indefinitely: the block stalls; acready stays 0.
- Single-beat line (beats=1): cdlast=1 on the only beat.
- Address arithmetic is modulo the line; no carry into the line tag bits.

Decomposition:
- Package ace_snoop_pkg holds:
  - snoop opcode localparams
  - crresp bit-index constants
  - FSM enum {IDLE, LOOKUP, RESP, DATA}
  - function snoop_decode(acsnoop, hit, unique, dirty), returning a struct of crresp/need_data/upd_inval/upd_clr_dirty
- Sub-module ace_snoop_cd_pipe: beat counter, wrap addressing, rd_en issue and skid output register for the CD channel.

Test Plan:
- ReadShared, hit, unique=1 dirty=1, acaddr=0x1030, 4 beats of 16B -> crresp=5'b11101; upd_clr_dirty pulse at 0x1000; CD beats from rd_addr 0x1030, 0x1000, 0x1010, 0x1020; cdlast on the 4th beat.
- CleanInvalid, hit, clean -> crresp=5'b10000 (WasUnique=unique=1); no CD; upd_inval=1.
- ReadUnique, miss -> crresp=0; no CD; no upd_valid; acready back to 1 one cycle after the CR handshake.
- acsnoop=4'b0101 -> crresp=5'b00010; no update or data.
- ReadOnce hit with cdready toggling 1,0,0,1,... -> cddata stable while stalled, exactly 4 beats, data matches rd_data order.
- ARESETn asserted during the 2nd CD beat -> all valids 0 immediately, acready=1 after release, no upd_valid; the next snoop completes normally.
